// File: rtl/finger_count_sequencer.sv
// Finger-count sequencer: qualifies a stable hand state, converts it, presents it on valid/ready.
// Optional stats counters are enabled by defining FINGER_COUNT_SEQ_STATS_EN.

// Counts raised fingers, one per bit (0..5).
module b_1_converter (
  input  logic [4:0] hs,
  output logic [3:0] num
);
  always_comb begin
    num = {3'b000, hs[0]} + {3'b000, hs[1]} + {3'b000, hs[2]} +
          {3'b000, hs[3]} + {3'b000, hs[4]};
  end
endmodule

// Abacus-style count: the thumb (bit 4) is worth five, each other finger one (0..9).
module b_2_converter (
  input  logic [4:0] hs,
  output logic [3:0] num
);
  always_comb begin
    num = (hs[4] ? 4'd5 : 4'd0) + {3'b000, hs[0]} + {3'b000, hs[1]} +
          {3'b000, hs[2]} + {3'b000, hs[3]};
  end
endmodule

module finger_count_sequencer #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [4:0] hs_in,
  input  logic       mode_sel,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_num,
  output logic [4:0] out_hs,
  output logic       out_mode,
`ifdef FINGER_COUNT_SEQ_STATS_EN
  output logic [7:0] conv_count,
  output logic [7:0] glitch_count,
`endif
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, SETTLE, CONVERT, HOLD, RELEASE} state_t;

  state_t             state_q, state_d;
  logic [4:0]         hs_q, hs_d;
  logic [4:0]         hs_cap_q, hs_cap_d;
  logic               mode_cap_q, mode_cap_d;
  logic [CNT_W-1:0]   stab_cnt_q, stab_cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [3:0]         out_num_q, out_num_d;
  logic [4:0]         out_hs_q, out_hs_d;
  logic               out_mode_q, out_mode_d;
  logic [3:0]         num_b1, num_b2;
  logic               handshake;
  logic               glitch;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic inc);
    sat_inc8 = (inc && v != 8'hFF) ? v + 8'd1 : v;
  endfunction

  b_1_converter u_b1 (.hs(hs_cap_q), .num(num_b1));
  b_2_converter u_b2 (.hs(hs_cap_q), .num(num_b2));

  always_comb begin
    state_d     = state_q;
    hs_d        = hs_q;
    hs_cap_d    = hs_cap_q;
    mode_cap_d  = mode_cap_q;
    stab_cnt_d  = stab_cnt_q;
    out_valid_d = out_valid_q;
    out_num_d   = out_num_q;
    out_hs_d    = out_hs_q;
    out_mode_d  = out_mode_q;
    handshake   = 1'b0;
    glitch      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          state_d    = SETTLE;
          hs_d       = hs_in;
          stab_cnt_d = '0;
        end
      end
      SETTLE: begin
        if (!en) begin
          state_d = IDLE;
        end else if (stab_cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
          state_d    = CONVERT;
          hs_cap_d   = hs_q;
          mode_cap_d = mode_sel;
        end else if (hs_in == hs_q) begin
          stab_cnt_d = stab_cnt_q + CNT_W'(1);
        end else begin
          hs_d       = hs_in;
          stab_cnt_d = '0;
          glitch     = 1'b1;
        end
      end
      CONVERT: begin
        out_num_d   = mode_cap_q ? num_b2 : num_b1;
        out_hs_d    = hs_cap_q;
        out_mode_d  = mode_cap_q;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        // en is deliberately ignored: a presented result is never withdrawn.
        if (out_valid_q && out_ready) begin
          handshake   = 1'b1;
          out_valid_d = 1'b0;
          state_d     = RELEASE;
        end
      end
      RELEASE: begin
        if (!en) begin
          state_d = IDLE;
        end else if (hs_in != hs_cap_q) begin
          state_d    = SETTLE;
          hs_d       = hs_in;
          stab_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hs_q        <= '0;
      hs_cap_q    <= '0;
      mode_cap_q  <= 1'b0;
      stab_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_num_q   <= '0;
      out_hs_q    <= '0;
      out_mode_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hs_q        <= hs_d;
      hs_cap_q    <= hs_cap_d;
      mode_cap_q  <= mode_cap_d;
      stab_cnt_q  <= stab_cnt_d;
      out_valid_q <= out_valid_d;
      out_num_q   <= out_num_d;
      out_hs_q    <= out_hs_d;
      out_mode_q  <= out_mode_d;
    end
  end

`ifdef FINGER_COUNT_SEQ_STATS_EN
  logic [7:0] conv_count_q, conv_count_d;
  logic [7:0] glitch_count_q, glitch_count_d;

  always_comb begin
    conv_count_d   = sat_inc8(conv_count_q, handshake);
    glitch_count_d = sat_inc8(glitch_count_q, glitch);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      conv_count_q   <= '0;
      glitch_count_q <= '0;
    end else begin
      conv_count_q   <= conv_count_d;
      glitch_count_q <= glitch_count_d;
    end
  end

  assign conv_count   = conv_count_q;
  assign glitch_count = glitch_count_q;
`else
  logic unused_stats;
  assign unused_stats = ^{handshake, glitch, sat_inc8(8'd0, 1'b0)};
`endif

  assign out_valid = out_valid_q;
  assign out_num   = out_num_q;
  assign out_hs    = out_hs_q;
  assign out_mode  = out_mode_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_finger_count_sequencer.sv
// Directed bench for finger_count_sequencer: table of conversions plus multi-cycle corner sequences.
module tb_finger_count_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [4:0] hs_in;
  logic       mode_sel;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_num;
  logic [4:0] out_hs;
  logic       out_mode;
  logic       busy;
`ifdef FINGER_COUNT_SEQ_STATS_EN
  logic [7:0] conv_count;
  logic [7:0] glitch_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  finger_count_sequencer #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .hs_in(hs_in), .mode_sel(mode_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_num(out_num),
    .out_hs(out_hs), .out_mode(out_mode),
`ifdef FINGER_COUNT_SEQ_STATS_EN
    .conv_count(conv_count), .glitch_count(glitch_count),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] hs;
    logic       mode;
    logic [3:0] exp_num;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; hs_in = '0; mode_sel = 1'b0; out_ready = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // Steps until out_valid is seen; returns the number of edges taken (31 if it never came).
  task automatic wait_valid(output int edges);
    edges = 0;
    do begin
      step();
      edges++;
    end while (!out_valid && edges <= 30);
  endtask

  initial begin
    int e;
    int nv;
    vecs[0]  = '{5'd7,  1'b0, 4'd3};
    vecs[1]  = '{5'd21, 1'b1, 4'd7};
    vecs[2]  = '{5'd21, 1'b0, 4'd3};
    vecs[3]  = '{5'd31, 1'b0, 4'd5};
    vecs[4]  = '{5'd31, 1'b1, 4'd9};
    vecs[5]  = '{5'd0,  1'b0, 4'd0};
    vecs[6]  = '{5'd0,  1'b1, 4'd0};
    vecs[7]  = '{5'd16, 1'b1, 4'd5};
    vecs[8]  = '{5'd16, 1'b0, 4'd1};
    vecs[9]  = '{5'd15, 1'b1, 4'd4};
    vecs[10] = '{5'd26, 1'b0, 4'd3};
    vecs[11] = '{5'd26, 1'b1, 4'd7};

    do_reset();
    check("reset out_valid", out_valid, 0);
    check("reset out_num", out_num, 0);
    check("reset out_hs", out_hs, 0);
    check("reset out_mode", out_mode, 0);
    check("reset busy", busy, 0);
`ifdef FINGER_COUNT_SEQ_STATS_EN
    check("reset conv_count", conv_count, 0);
    check("reset glitch_count", glitch_count, 0);
`endif

    // Table: latency, result fields and single-cycle valid with out_ready tied high.
    for (int i = 0; i < 12; i++) begin
      do_reset();
      hs_in = vecs[i].hs; mode_sel = vecs[i].mode; out_ready = 1'b1; en = 1'b1;
      wait_valid(e);
      check($sformatf("vec%0d latency", i), e, 6);
      check($sformatf("vec%0d out_num", i), out_num, vecs[i].exp_num);
      check($sformatf("vec%0d out_hs", i), out_hs, vecs[i].hs);
      check($sformatf("vec%0d out_mode", i), out_mode, vecs[i].mode);
      check($sformatf("vec%0d busy", i), busy, 1);
      step();
      check($sformatf("vec%0d valid one cycle", i), out_valid, 0);
    end

    // Glitch restart: 3,3,11 then 3 held.
    do_reset();
    out_ready = 1'b1; mode_sel = 1'b0; hs_in = 5'd3; en = 1'b1;
    step(); step();
    hs_in = 5'd11; step();
    hs_in = 5'd3;
    wait_valid(e);
    check("glitch latency", e, 6);
    check("glitch out_hs", out_hs, 3);
    check("glitch out_num", out_num, 2);
`ifdef FINGER_COUNT_SEQ_STATS_EN
    check("glitch glitch_count", glitch_count, 2);
`endif

    // Backpressure: result frozen while out_ready low and inputs wander.
    do_reset();
    out_ready = 1'b0; mode_sel = 1'b0; hs_in = 5'd7; en = 1'b1;
    wait_valid(e);
    check("bp latency", e, 6);
    for (int c = 0; c < 10; c++) begin
      hs_in = 5'(c * 3 + 1); mode_sel = ~mode_sel; en = c[0];
      step();
      check($sformatf("bp valid c%0d", c), out_valid, 1);
      check($sformatf("bp num c%0d", c), out_num, 3);
      check($sformatf("bp hs c%0d", c), out_hs, 7);
      check($sformatf("bp mode c%0d", c), out_mode, 0);
    end
    en = 1'b1; out_ready = 1'b1;
    step();
    check("bp handshake valid", out_valid, 0);
    check("bp release busy", busy, 1);
`ifdef FINGER_COUNT_SEQ_STATS_EN
    check("bp conv_count", conv_count, 1);
`endif

    // Repeat suppression of a held gesture, then re-emission on change.
    do_reset();
    out_ready = 1'b1; mode_sel = 1'b1; hs_in = 5'd31; en = 1'b1;
    wait_valid(e);
    check("rep first latency", e, 6);
    check("rep first num", out_num, 9);
    nv = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (out_valid) nv++;
    end
    check("rep suppressed valids", nv, 0);
    check("rep busy in release", busy, 1);
    hs_in = 5'd0;
    wait_valid(e);
    check("rep second latency", e, 6);
    check("rep second num", out_num, 0);
    check("rep second hs", out_hs, 0);
    check("rep second mode", out_mode, 1);

    // Abort: en dropped mid-SETTLE returns to IDLE with no output.
    do_reset();
    out_ready = 1'b1; mode_sel = 1'b1; hs_in = 5'd21; en = 1'b1;
    step(); step();
    check("abort busy settle", busy, 1);
    en = 1'b0;
    step();
    check("abort busy idle", busy, 0);
    nv = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (out_valid) nv++;
    end
    check("abort no valid", nv, 0);

    // Reset while a result is held.
    do_reset();
    out_ready = 1'b0; mode_sel = 1'b1; hs_in = 5'd21; en = 1'b1;
    wait_valid(e);
    check("rsthold latency", e, 6);
    check("rsthold pre mode", out_mode, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; en = 1'b0;
    check("rsthold valid", out_valid, 0);
    check("rsthold num", out_num, 0);
    check("rsthold hs", out_hs, 0);
    check("rsthold mode", out_mode, 0);
    check("rsthold busy", busy, 0);
    step();
    check("rsthold stays idle", busy, 0);
    check("rsthold no valid", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
